// File: rtl/wb_noc_gateway.sv
// wb_noc_gateway: Wishbone write slave feeding a small FIFO, drained as
// two-flit packets (head = dest/address, tail = data) onto a valid/ready NoC link.
// Optional macro NOC_GW_PARITY_EN: widens the flit to 35 bits, bit 34 = even parity.
module wb_noc_gateway #(
  parameter int FIFO_DEPTH = 4,
  parameter int DEST_W     = 4,
`ifdef NOC_GW_PARITY_EN
  localparam int FLIT_W    = 35,
`else
  localparam int FLIT_W    = 34,
`endif
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       wbs_adr,
  input  logic [31:0]       wbs_dat,
  input  logic              wbs_cyc,
  input  logic              wbs_stb,
  input  logic              wbs_we,
  output logic              wbs_ack,
  output logic [FLIT_W-1:0] noc_flit,
  output logic              noc_valid,
  input  logic              noc_ready,
  output logic [CW-1:0]     fifo_count,
  output logic              rd_err,
  output logic [15:0]       pkt_sent
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  typedef enum logic [1:0] {IDLE, HEAD, TAIL} tx_state_t;

  tx_state_t     state, state_nxt;
  wb_req_t       mem [FIFO_DEPTH];
  wb_req_t       front;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          req, full, push, pop;
  logic [33:0]   flit_base;

  // The !ack term keeps a lingering strobe from pushing the same write twice.
  assign req   = wbs_cyc & wbs_stb & ~wbs_ack;
  // Full uses the registered count, so a same-cycle pop never makes room.
  assign full  = (fifo_count == CW'(FIFO_DEPTH));
  assign push  = req & wbs_we & ~full;
  assign pop   = (state == TAIL) & noc_ready;
  assign front = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CW'(1);
      2'b01:   count_nxt = fifo_count - CW'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // Write buffer storage; contents need no reset, occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{adr: wbs_adr, dat: wbs_dat};
  end

  // Pointers, count, ack, sticky read error and packet counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wbs_ack    <= 1'b0;
      rd_err     <= 1'b0;
      pkt_sent   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        pkt_sent <= pkt_sent + 16'd1;
      end
      fifo_count <= count_nxt;
      wbs_ack    <= req & (~wbs_we | ~full);
      if (req & ~wbs_we) rd_err <= 1'b1;
    end
  end

  // Transmit state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and flit decode; outputs depend only on state and FIFO front.
  always_comb begin
    state_nxt = state;
    noc_valid = 1'b0;
    flit_base = '0;
    case (state)
      IDLE: if (fifo_count != '0) state_nxt = HEAD;
      HEAD: begin
        noc_valid = 1'b1;
        flit_base = {2'b10, front.adr[31:32-DEST_W], front.adr[31-DEST_W:0]};
        if (noc_ready) state_nxt = TAIL;
      end
      TAIL: begin
        noc_valid = 1'b1;
        flit_base = {2'b01, front.dat};
        // Chain straight into the next head when more entries remain.
        if (noc_ready) state_nxt = (count_nxt != '0) ? HEAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef NOC_GW_PARITY_EN
  assign noc_flit = {^flit_base, flit_base};
`else
  assign noc_flit = flit_base;
`endif

endmodule

// File: tb/tb_wb_noc_gateway.sv
// Directed bench for wb_noc_gateway: a per-cycle vector table for the basic
// write/read path, plus sequences for stall-on-full, ready toggling, reset
// mid-packet and parity.
`timescale 1ns/1ps
module tb_wb_noc_gateway;
`ifdef NOC_GW_PARITY_EN
  localparam int FW = 35;
`else
  localparam int FW = 34;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   wbs_adr, wbs_dat;
  logic          wbs_cyc, wbs_stb, wbs_we, wbs_ack;
  logic [FW-1:0] noc_flit;
  logic          noc_valid, noc_ready;
  logic [2:0]    fifo_count;
  logic          rd_err;
  logic [15:0]   pkt_sent;

  int errors = 0;
  int checks = 0;
  logic [FW-1:0] flog[$];
  logic [FW-1:0] elog[$];

  always #5 clk = ~clk;

  wb_noc_gateway dut (
    .clk(clk), .reset(reset),
    .wbs_adr(wbs_adr), .wbs_dat(wbs_dat), .wbs_cyc(wbs_cyc),
    .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_ack(wbs_ack),
    .noc_flit(noc_flit), .noc_valid(noc_valid), .noc_ready(noc_ready),
    .fifo_count(fifo_count), .rd_err(rd_err), .pkt_sent(pkt_sent)
  );

  // Log every accepted flit.
  always @(posedge clk)
    if (!reset && noc_valid && noc_ready) flog.push_back(noc_flit);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [FW-1:0] fx(input logic [33:0] f);
`ifdef NOC_GW_PARITY_EN
    return {^f, f};
`else
    return f;
`endif
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    int k;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = a; wbs_dat = d;
    k = 0;
    do begin @(negedge clk); k++; end while (!wbs_ack && k < 20);
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    if (!wbs_ack) begin
      checks++; errors++;
      $display("FAIL wr_timeout: no ack for adr %h", a);
    end
  endtask

  task automatic wait_empty(input string n);
    int k;
    k = 0;
    while ((fifo_count != 0 || noc_valid) && k < 60) begin @(negedge clk); k++; end
    if (k >= 60) begin
      checks++; errors++;
      $display("FAIL %s: drain timeout, count %0d", n, fifo_count);
    end
  endtask

  task automatic check_log(input string n);
    chk({n, "_len"}, 64'(flog.size()), 64'(elog.size()));
    for (int i = 0; i < elog.size() && i < flog.size(); i++)
      chk($sformatf("%s_flit%0d", n, i), 64'(flog[i]), 64'(elog[i]));
  endtask

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] adr, dat;
    logic        rdy;
    logic        ack, vld;
    logic [33:0] flit;
    logic [2:0]  cnt;
    logic        rde;
    logic [15:0] pkt;
  } vec_t;

  vec_t tbl[8];
  logic [31:0]   a5[5], d5[5];
  logic          prev_v, prev_r;
  logic [FW-1:0] prev_f;

  initial begin
    // cyc stb we adr dat rdy | ack vld flit cnt rd_err pkt
    tbl[0] = '{1,1,1,32'h3000_0010,32'hDEAD_BEEF,1, 0,0,34'h0,           3'd0,0,16'd0};
    tbl[1] = '{1,1,1,32'h3000_0010,32'hDEAD_BEEF,1, 1,0,34'h0,           3'd1,0,16'd0};
    tbl[2] = '{0,0,0,32'h0,        32'h0,        1, 0,1,34'h2_3000_0010, 3'd1,0,16'd0};
    tbl[3] = '{0,0,0,32'h0,        32'h0,        1, 0,1,34'h1_DEAD_BEEF, 3'd1,0,16'd0};
    tbl[4] = '{0,0,0,32'h0,        32'h0,        1, 0,0,34'h0,           3'd0,0,16'd1};
    tbl[5] = '{1,1,0,32'h0,        32'h0,        1, 0,0,34'h0,           3'd0,0,16'd1};
    tbl[6] = '{1,1,0,32'h0,        32'h0,        1, 1,0,34'h0,           3'd0,1,16'd1};
    tbl[7] = '{0,0,0,32'h0,        32'h0,        1, 0,0,34'h0,           3'd0,1,16'd1};

    reset = 1'b1; wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_adr = '0; wbs_dat = '0;
    noc_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {wbs_ack, noc_valid, 64'(noc_flit), fifo_count, rd_err, pkt_sent}, '0);
    reset = 1'b0;

    // Basic write then read, one row per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wbs_cyc = tbl[i].cyc; wbs_stb = tbl[i].stb; wbs_we = tbl[i].we;
      wbs_adr = tbl[i].adr; wbs_dat = tbl[i].dat; noc_ready = tbl[i].rdy;
      chk($sformatf("vec%0d", i),
          {wbs_ack, noc_valid, noc_flit, fifo_count, rd_err, pkt_sent},
          {tbl[i].ack, tbl[i].vld, fx(tbl[i].flit), tbl[i].cnt, tbl[i].rde, tbl[i].pkt});
    end
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
    @(negedge clk);

    // Fill to full with router stalled; the fifth write must wait for a pop.
    noc_ready = 1'b0; flog.delete(); elog.delete();
    for (int i = 0; i < 5; i++) begin
      a5[i] = 32'h5000_0100 + 32'(i * 4);
      d5[i] = 32'hC0DE_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) bus_write(a5[i], d5[i]);
    chk("full_count", 64'(fifo_count), 64'd4);
    wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_adr = a5[4]; wbs_dat = d5[4];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall_ack%0d", i), {wbs_ack, fifo_count}, {1'b0, 3'd4});
    end
    noc_ready = 1'b1;
    @(negedge clk); chk("full_tail_ack", 64'(wbs_ack), 64'd0);
    @(negedge clk); chk("full_pop_ack", {wbs_ack, fifo_count}, {1'b0, 3'd3});
    @(negedge clk); chk("late_ack", 64'(wbs_ack), 64'd1);
    wbs_cyc = 0; wbs_stb = 0; wbs_we = 0;
    wait_empty("full_drain");
    for (int i = 0; i < 5; i++) begin
      elog.push_back(fx({2'b10, a5[i]}));
      elog.push_back(fx({2'b01, d5[i]}));
    end
    check_log("full");
    chk("full_pkt", 64'(pkt_sent), 64'd6);

    // Router ready toggling: flits must hold while not accepted.
    noc_ready = 1'b0; flog.delete(); elog.delete();
    for (int i = 0; i < 3; i++) begin
      a5[i] = 32'hA000_0040 + 32'(i * 16);
      d5[i] = 32'h1234_5670 + 32'(i);
      bus_write(a5[i], d5[i]);
      elog.push_back(fx({2'b10, a5[i]}));
      elog.push_back(fx({2'b01, d5[i]}));
    end
    prev_v = 1'b0; prev_r = 1'b0; prev_f = '0;
    for (int c = 0; c < 14; c++) begin
      if (prev_v && !prev_r)
        chk($sformatf("hold%0d", c), {noc_valid, noc_flit}, {1'b1, prev_f});
      noc_ready = c[0];
      prev_v = noc_valid; prev_f = noc_flit; prev_r = noc_ready;
      @(negedge clk);
    end
    noc_ready = 1'b1;
    wait_empty("toggle_drain");
    check_log("toggle");
    chk("toggle_pkt", 64'(pkt_sent), 64'd9);

    // Reset while in TAIL with two entries queued.
    noc_ready = 1'b0;
    bus_write(32'h7000_0000, 32'h0000_AAAA);
    bus_write(32'h7000_0004, 32'h0000_BBBB);
    noc_ready = 1'b1;
    @(negedge clk);
    noc_ready = 1'b0;
    chk("in_tail", {noc_valid, noc_flit, fifo_count}, {1'b1, fx({2'b01, 32'h0000_AAAA}), 3'd2});
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset", {wbs_ack, noc_valid, 64'(noc_flit), fifo_count, rd_err, pkt_sent}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {noc_valid, fifo_count}, {1'b0, 3'd0});

    // Single packet to address 0, data 1 (parity corner).
    noc_ready = 1'b1; flog.delete(); elog.delete();
    bus_write(32'h0, 32'h1);
    wait_empty("par_drain");
    elog.push_back(fx(34'h2_0000_0000));
    elog.push_back(fx(34'h1_0000_0001));
    check_log("par");
`ifdef NOC_GW_PARITY_EN
    if (flog.size() == 2) begin
      chk("par_head_bit", 64'(flog[0][34]), 64'd1);
      chk("par_tail_bit", 64'(flog[1][34]), 64'd0);
    end else begin
      checks++; errors++;
      $display("FAIL par_bits: got %0d flits expected 2", flog.size());
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
